decode_stage_pipelined: RTL and testbench
=========================================

Name: decode_stage_pipelined

Overview:
Parametrised successor of the combinational decode stage. It decodes one RV32 instruction per accepted transfer and reads its operands from an internal parametrised register file. Results are registered into an ID/EX output stage with valid/ready handshakes on both sides. It also detects load-use hazards, supports pipeline flush, and captures the PC of the first illegal instruction in a sticky record.

Parameters:
XLEN, 32, data/PC width.
NUM_REGS, 32, architectural register count (16 for RV32E); allowed range 2..32.
REG_ID_W, 5, register index width; fixed to the instruction field width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
flush  in  1  discard the output-stage contents and the current input
in_valid  in  1  instruction/pc_in valid
in_ready  out  1  stage accepts input this cycle
instruction  in  32  instruction_type word
pc_in  in  XLEN  PC of instruction
wb_en  in  1  register-file write enable
wb_id  in  REG_ID_W  write index
wb_data  in  XLEN  write data
ex_is_load  in  1  instruction now in EX is a load
ex_rd_id  in  REG_ID_W  destination register of EX instruction
out_valid  out  1  output stage holds a valid instruction
out_ready  in  1  EX accepts output
out_rd_id, out_rs1_id, out_rs2_id  out  REG_ID_W each  register indices
out_read_data1, out_read_data2  out  XLEN each  operand values
out_imm  out  XLEN  immediate_extension result
out_pc  out  XLEN  registered pc_in
out_control  out  control_type  registered control-unit output
out_illegal  out  1  registered instruction is illegal
illegal_seen  out  1  sticky: an illegal instruction was accepted
illegal_pc  out  XLEN  PC of the first accepted illegal instruction
illegal_clear  in  1  clears illegal_seen and illegal_pc

Behaviour:
- Reset is asynchronous. It clears every output register, illegal_seen and illegal_pc to 0, and every register-file entry to 0. in_ready is 0 while reset is asserted.
- Decode is combinational from instruction, using the existing control unit and immediate_extension.
- Illegal instruction, evaluated combinationally:
  - the control unit reports a decode failure, OR
  - rs1 >= NUM_REGS where the encoding uses rs1 (R/I/S/B), OR
  - rs2 >= NUM_REGS where the encoding uses rs2 (R/S/B), OR
  - rd >= NUM_REGS where the encoding writes rd (R/I/U/J).
  - rd==0 is NOT illegal.
- Register file:
  - Reads of x0 always return 0.
  - A write occurs on the clock edge when wb_en=1 and wb_id!=0 and wb_id<NUM_REGS; all other writes are ignored.
- Hazard stall: stall=1 when in_valid=1 and ex_is_load=1 and ex_rd_id!=0 and ex_rd_id equals a source register used by the encoding.
- Handshake:
  - in_ready = !flush && !stall && (!out_valid || out_ready).
  - Accept = in_valid && in_ready. On accept, all out_* registers load next edge and out_valid<=1. Latency is 1 cycle.
  - When there is no accept and out_ready=1, out_valid<=0. When stall=1 and out_ready=1, this inserts exactly one bubble per stalled cycle.
  - When out_valid=1 and out_ready=0, all out_* signals hold stable.
- Flush has priority over accept and stall: out_valid<=0 next edge, and the presented input is not accepted. Data registers may keep stale values; only out_valid is meaningful.
- Sticky illegal record:
  - Set on the first accepted illegal instruction: illegal_seen<=1, illegal_pc<=pc_in.
  - Later illegal instructions do not overwrite it.
  - illegal_clear resets the record. If illegal_clear and an illegal accept occur in the same cycle, the record is cleared then set, capturing the new PC.
  - Flushed or non-accepted instructions never set the record.
- A simultaneous write and read of the same register returns the old value; see Optional Feature.

Optional Feature:
Macro DECODE_WB_BYPASS_EN.
- Defined: when wb_en=1 and wb_id==rs (rs!=0) in the accept cycle, the operand read returns wb_data (write-through). No extra latency.
- Undefined: the operand returns the pre-write register value; downstream forwarding is responsible.

Test Plan:
- Reset, then write x5=0x0000_00AA; accept ADD x3,x5,x0 with pc_in=0x100 -> after 1 cycle out_valid=1, out_read_data1=0xAA, out_read_data2=0, out_pc=0x100, out_illegal=0.
- out_ready=0 for 3 cycles with a new in_valid presented -> in_ready=0, all outputs stable; out_ready=1 -> next instruction loads the following cycle.
- ex_is_load=1, ex_rd_id=5, incoming SW x5,0(x6) -> in_ready=0, one bubble (out_valid=0); ex_is_load=0 -> accepted next cycle.
- NUM_REGS=16, ADDI x20,x1,1 at pc=0x200, followed by an illegal opcode at pc=0x204 -> out_illegal=1 for both, illegal_seen=1, illegal_pc=0x200; illegal_clear -> both 0.
- flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, instruction not accepted, illegal record unchanged.
- wb_en=1, wb_id=7, wb_data=0x1234, same-cycle accept reading x7 -> out_read_data1=0x1234 with DECODE_WB_BYPASS_EN defined, old value without it; a write to x0 leaves x0 reading 0.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// Pipelined RV32 decode stage: register-file read, decode and ID/EX output register with valid/ready.
// Optional macro DECODE_WB_BYPASS_EN makes a same-cycle write-back visible to the operand read.

package decode_stage_pipelined_pkg;
   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic [3:0] alu_op;
   } control_type;
endpackage

module decode_stage_pipelined
   import decode_stage_pipelined_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int REG_ID_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instruction,
   input  logic [XLEN-1:0]     pc_in,
   input  logic                wb_en,
   input  logic [REG_ID_W-1:0] wb_id,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                ex_is_load,
   input  logic [REG_ID_W-1:0] ex_rd_id,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [REG_ID_W-1:0] out_rd_id,
   output logic [REG_ID_W-1:0] out_rs1_id,
   output logic [REG_ID_W-1:0] out_rs2_id,
   output logic [XLEN-1:0]     out_read_data1,
   output logic [XLEN-1:0]     out_read_data2,
   output logic [XLEN-1:0]     out_imm,
   output logic [XLEN-1:0]     out_pc,
   output control_type         out_control,
   output logic                out_illegal,
   output logic                illegal_seen,
   output logic [XLEN-1:0]     illegal_pc,
   input  logic                illegal_clear
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [6:0]          opcode;
   logic [2:0]          f3;
   logic [6:0]          f7;
   logic [REG_ID_W-1:0] rs1_id, rs2_id, rd_id;

   assign opcode = instruction[6:0];
   assign f3     = instruction[14:12];
   assign f7     = instruction[31:25];
   assign rs1_id = REG_ID_W'(instruction[19:15]);
   assign rs2_id = REG_ID_W'(instruction[24:20]);
   assign rd_id  = REG_ID_W'(instruction[11:7]);

   function automatic logic id_ok(input logic [REG_ID_W-1:0] id);
      return int'(id) < NUM_REGS;
   endfunction

   // Control unit and immediate extension; operand usage follows the encoding format.
   control_type ctrl;
   logic        dec_ok, use_rs1, use_rs2, use_rd;
   logic [31:0] imm32;

   always_comb begin
      ctrl    = '0;
      dec_ok  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      imm32   = '0;
      case (opcode)
         OP_R: begin
            {use_rs1, use_rs2, use_rd} = 3'b111;
            dec_ok         = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = {f7[5], f3};
         end
         OP_IMM: begin
            {use_rs1, use_rd} = 2'b11;
            imm32          = {{20{instruction[31]}}, instruction[31:20]};
            dec_ok         = (f3 == 3'd1) ? (f7 == 7'h00) :
                             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = {(f3 == 3'd5) & f7[5], f3};
         end
         OP_LOAD: begin
            {use_rs1, use_rd} = 2'b11;
            imm32           = {{20{instruction[31]}}, instruction[31:20]};
            dec_ok          = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_STORE: begin
            {use_rs1, use_rs2} = 2'b11;
            imm32          = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            dec_ok         = (f3 <= 3'd2);
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            {use_rs1, use_rs2} = 2'b11;
            imm32       = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
            dec_ok      = (f3 != 3'd2) && (f3 != 3'd3);
            ctrl.branch = 1'b1;
            ctrl.alu_op = 4'b1000;
         end
         OP_JAL: begin
            use_rd         = 1'b1;
            imm32          = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            dec_ok         = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
         end
         OP_JALR: begin
            {use_rs1, use_rd} = 2'b11;
            imm32          = {{20{instruction[31]}}, instruction[31:20]};
            dec_ok         = (f3 == 3'd0);
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.jalr      = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            use_rd         = 1'b1;
            imm32          = {instruction[31:12], 12'h000};
            dec_ok         = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = (opcode == OP_LUI) ? 4'b1111 : 4'b0000;
         end
         default: ;
      endcase
      if (!dec_ok) ctrl = '0;
   end

   logic illegal;
   assign illegal = !dec_ok
                  || (use_rs1 && !id_ok(rs1_id))
                  || (use_rs2 && !id_ok(rs2_id))
                  || (use_rd  && !id_ok(rd_id));

   // Register file; x0 is not stored and reads as zero.
   logic [XLEN-1:0] rf_q [1:NUM_REGS-1];
   logic [XLEN-1:0] rdata1, rdata2;

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (rs1_id == REG_ID_W'(r)) rdata1 = rf_q[r];
         if (rs2_id == REG_ID_W'(r)) rdata2 = rf_q[r];
      end
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && rs1_id != '0 && wb_id == rs1_id) rdata1 = wb_data;
      if (wb_en && rs2_id != '0 && wb_id == rs2_id) rdata2 = wb_data;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 1; r < NUM_REGS; r++) rf_q[r] <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++)
            if (wb_en && wb_id == REG_ID_W'(r)) rf_q[r] <= wb_data;
      end
   end

   logic stall, accept;
   logic out_valid_q, out_valid_d;

   assign stall = in_valid && ex_is_load && ex_rd_id != '0
                && ((use_rs1 && ex_rd_id == rs1_id) || (use_rs2 && ex_rd_id == rs2_id));
   assign in_ready = !reset && !flush && !stall && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush)          out_valid_d = 1'b0;
      else if (accept)    out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   logic [REG_ID_W-1:0] rd_q, rs1_q, rs2_q;
   logic [XLEN-1:0]     rdata1_q, rdata2_q, imm_q, pc_q;
   control_type         ctrl_q;
   logic                illegal_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         ctrl_q      <= '0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (accept) begin
            rd_q      <= rd_id;
            rs1_q     <= rs1_id;
            rs2_q     <= rs2_id;
            rdata1_q  <= rdata1;
            rdata2_q  <= rdata2;
            imm_q     <= XLEN'($signed(imm32));
            pc_q      <= pc_in;
            ctrl_q    <= ctrl;
            illegal_q <= illegal;
         end
      end
   end

   // Clear is applied before capture so a same-cycle illegal accept records its own PC.
   logic            seen_q, seen_d;
   logic [XLEN-1:0] ipc_q, ipc_d;

   always_comb begin
      seen_d = illegal_clear ? 1'b0 : seen_q;
      ipc_d  = illegal_clear ? '0   : ipc_q;
      if (accept && illegal && !seen_d) begin
         seen_d = 1'b1;
         ipc_d  = pc_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_q <= 1'b0;
         ipc_q  <= '0;
      end else begin
         seen_q <= seen_d;
         ipc_q  <= ipc_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_rd_id      = rd_q;
   assign out_rs1_id     = rs1_q;
   assign out_rs2_id     = rs2_q;
   assign out_read_data1 = rdata1_q;
   assign out_read_data2 = rdata2_q;
   assign out_imm        = imm_q;
   assign out_pc         = pc_q;
   assign out_control    = ctrl_q;
   assign out_illegal    = illegal_q;
   assign illegal_seen   = seen_q;
   assign illegal_pc     = ipc_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined (NUM_REGS=16): directed scenarios plus random traffic vs. a reference model.
module tb_decode_stage_pipelined;
   import decode_stage_pipelined_pkg::*;

   localparam int NR = 16;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, wb_en, ex_is_load, out_valid, out_ready;
   logic [31:0] instruction, pc_in, wb_data;
   logic [4:0]  wb_id, ex_rd_id, out_rd_id, out_rs1_id, out_rs2_id;
   logic [31:0] out_read_data1, out_read_data2, out_imm, out_pc, illegal_pc;
   control_type out_control;
   logic        out_illegal, illegal_seen, illegal_clear;

   int n_checks = 0;
   int n_err    = 0;

   decode_stage_pipelined #(.XLEN(32), .NUM_REGS(NR), .REG_ID_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc_in(pc_in), .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
      .ex_is_load(ex_is_load), .ex_rd_id(ex_rd_id), .out_valid(out_valid), .out_ready(out_ready),
      .out_rd_id(out_rd_id), .out_rs1_id(out_rs1_id), .out_rs2_id(out_rs2_id),
      .out_read_data1(out_read_data1), .out_read_data2(out_read_data2), .out_imm(out_imm),
      .out_pc(out_pc), .out_control(out_control), .out_illegal(out_illegal),
      .illegal_seen(illegal_seen), .illegal_pc(illegal_pc), .illegal_clear(illegal_clear));

   always #5 clk = ~clk;

   // Reference model state
   logic        m_valid, m_ill, m_seen;
   logic [4:0]  m_rd, m_rs1, m_rs2, m_ctl;
   logic [31:0] m_d1, m_d2, m_imm, m_pc, m_ipc;
   logic [31:0] mrf [32];

   function automatic logic [31:0] sext(input int v, input int bits);
      int r;
      r = (v ^ (1 << (bits - 1))) - (1 << (bits - 1));
      return 32'(r);
   endfunction

   // ctl = {reg_write, mem_read, mem_write, branch, jump}
   function automatic void ref_decode(input logic [31:0] ins, output bit u1, output bit u2,
                                      output bit ud, output bit ok, output logic [31:0] imm,
                                      output logic [4:0] ctl);
      int f3, f7;
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      u1 = 0; u2 = 0; ud = 0; ok = 0; imm = 0; ctl = 0;
      case (ins[6:0])
         7'h33: begin u1 = 1; u2 = 1; ud = 1; ok = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)); ctl = 5'b10000; end
         7'h13: begin u1 = 1; ud = 1; imm = sext(int'(ins[31:20]), 12); ctl = 5'b10000;
                      ok = (f3 == 1) ? f7 == 0 : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1; end
         7'h03: begin u1 = 1; ud = 1; imm = sext(int'(ins[31:20]), 12); ctl = 5'b11000;
                      ok = f3 inside {0, 1, 2, 4, 5}; end
         7'h23: begin u1 = 1; u2 = 1; imm = sext(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
                      ok = f3 < 3; ctl = 5'b00100; end
         7'h63: begin u1 = 1; u2 = 1; ok = f3 != 2 && f3 != 3; ctl = 5'b00010;
                      imm = sext(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                                 + int'(ins[11:8]) * 2, 13); end
         7'h6F: begin ud = 1; ok = 1; ctl = 5'b10001;
                      imm = sext(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096
                                 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21); end
         7'h67: begin u1 = 1; ud = 1; imm = sext(int'(ins[31:20]), 12); ok = f3 == 0; ctl = 5'b10001; end
         7'h37, 7'h17: begin ud = 1; ok = 1; imm = ins & 32'hFFFF_F000; ctl = 5'b10000; end
         default: ;
      endcase
      if (!ok) ctl = 0;
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] id);
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && id != 0 && wb_id == id) return wb_data;
`endif
      if (id == 0 || int'(id) >= NR) return 0;
      return mrf[id];
   endfunction

   function automatic bit ref_stall();
      bit u1, u2, ud, ok; logic [31:0] imm; logic [4:0] ctl;
      ref_decode(instruction, u1, u2, ud, ok, imm, ctl);
      return in_valid && ex_is_load && ex_rd_id != 0 &&
             ((u1 && ex_rd_id == instruction[19:15]) || (u2 && ex_rd_id == instruction[24:20]));
   endfunction

   function automatic bit ref_ready();
      return !reset && !flush && !ref_stall() && (!m_valid || out_ready);
   endfunction

   function automatic void model_reset();
      m_valid = 0; m_ill = 0; m_seen = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_ctl = 0;
      m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; m_ipc = 0;
      for (int i = 0; i < 32; i++) mrf[i] = 0;
   endfunction

   // Advance one clock: compute the model's next state from the pre-edge inputs, then sample at edge+1.
   task automatic tick();
      bit u1, u2, ud, ok, acc, ill; logic [31:0] imm, d1, d2; logic [4:0] ctl;
      ref_decode(instruction, u1, u2, ud, ok, imm, ctl);
      acc = in_valid && ref_ready();
      ill = !ok || (u1 && int'(instruction[19:15]) >= NR) || (u2 && int'(instruction[24:20]) >= NR)
            || (ud && int'(instruction[11:7]) >= NR);
      d1 = ref_read(instruction[19:15]);
      d2 = ref_read(instruction[24:20]);
      @(posedge clk);
      if (flush) m_valid = 0;
      else if (acc) begin
         m_valid = 1; m_rd = instruction[11:7]; m_rs1 = instruction[19:15]; m_rs2 = instruction[24:20];
         m_d1 = d1; m_d2 = d2; m_imm = imm; m_pc = pc_in; m_ctl = ctl; m_ill = ill;
      end else if (out_ready) m_valid = 0;
      if (illegal_clear) begin m_seen = 0; m_ipc = 0; end
      if (acc && ill && !m_seen) begin m_seen = 1; m_ipc = pc_in; end
      if (wb_en && wb_id != 0 && int'(wb_id) < NR) mrf[wb_id] = wb_data;
      #1;
   endtask

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33);
   endfunction
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
      return 32'(((imm & 12'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13);
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      return 32'((((imm >> 5) & 7'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                 | ((imm & 5'h1F) << 7) | 32'h23);
   endfunction

   task automatic set_idle();
      flush = 0; in_valid = 0; instruction = 0; pc_in = 0; wb_en = 0; wb_id = 0; wb_data = 0;
      ex_is_load = 0; ex_rd_id = 0; out_ready = 1; illegal_clear = 0;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1;
      in_valid = 1; instruction = enc_r(0, 0, 5, 0, 3);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++;
      if ({out_valid, illegal_seen, illegal_pc, out_pc, out_illegal} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b seen=%b ipc=%h pc=%h ill=%b want all 0",
                  out_valid, illegal_seen, illegal_pc, out_pc, out_illegal);
      end
      set_idle();
      @(negedge clk);
      reset = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      wb_en = 1; wb_id = 5; wb_data = 32'hAA;
      tick();
      wb_en = 0; in_valid = 1; instruction = enc_r(0, 0, 5, 0, 3); pc_in = 32'h100;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      tick();
      n_checks++;
      if ({out_valid, out_read_data1, out_read_data2, out_pc, out_illegal, out_rd_id}
          !== {1'b1, 32'hAA, 32'h0, 32'h100, 1'b0, 5'd3}) begin
         n_err++;
         $display("FAIL basic_add: got v=%b d1=%h d2=%h pc=%h ill=%b rd=%0d want 1 aa 0 100 0 3",
                  out_valid, out_read_data1, out_read_data2, out_pc, out_illegal, out_rd_id);
      end
   endtask

   task automatic test_backpressure();
      logic [137:0] snap;
      out_ready = 0; in_valid = 1; instruction = enc_i(7, 5, 0, 2); pc_in = 32'h104;
      snap = {out_valid, out_rd_id, out_read_data1, out_read_data2, out_imm, out_pc};
      #1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         tick();
         n_checks++;
         if ({out_valid, out_rd_id, out_read_data1, out_read_data2, out_imm, out_pc} !== snap) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got v=%b pc=%h d1=%h want v=1 pc=100 d1=aa", i, out_valid, out_pc, out_read_data1);
         end
      end
      out_ready = 1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      tick();
      n_checks++;
      if ({out_valid, out_pc, out_imm, out_rd_id, out_read_data1} !== {1'b1, 32'h104, 32'd7, 5'd2, 32'hAA}) begin
         n_err++;
         $display("FAIL bp_next: got v=%b pc=%h imm=%h rd=%0d d1=%h want 1 104 7 2 aa",
                  out_valid, out_pc, out_imm, out_rd_id, out_read_data1);
      end
   endtask

   task automatic test_stall();
      ex_is_load = 1; ex_rd_id = 5; in_valid = 1; instruction = enc_s(0, 5, 6, 2); pc_in = 32'h108;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_bubble: got out_valid=%b want 0", out_valid); end
      ex_is_load = 0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", in_ready); end
      tick();
      n_checks++;
      if ({out_valid, out_pc, out_rs2_id, out_control.mem_write, out_imm} !== {1'b1, 32'h108, 5'd5, 1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL stall_accept: got v=%b pc=%h rs2=%0d mw=%b imm=%h want 1 108 5 1 0",
                  out_valid, out_pc, out_rs2_id, out_control.mem_write, out_imm);
      end
   endtask

   task automatic test_illegal();
      in_valid = 1; instruction = enc_i(1, 1, 0, 20); pc_in = 32'h200;
      tick();
      n_checks++;
      if ({out_illegal, illegal_seen, illegal_pc} !== {1'b1, 1'b1, 32'h200}) begin
         n_err++; $display("FAIL ill_rd_range: got ill=%b seen=%b pc=%h want 1 1 200", out_illegal, illegal_seen, illegal_pc);
      end
      instruction = 32'h0000_007F; pc_in = 32'h204;
      tick();
      n_checks++;
      if ({out_illegal, out_pc, illegal_seen, illegal_pc} !== {1'b1, 32'h204, 1'b1, 32'h200}) begin
         n_err++; $display("FAIL ill_sticky: got ill=%b opc=%h seen=%b pc=%h want 1 204 1 200",
                           out_illegal, out_pc, illegal_seen, illegal_pc);
      end
      in_valid = 0; illegal_clear = 1;
      tick();
      n_checks++;
      if ({illegal_seen, illegal_pc} !== {1'b0, 32'h0}) begin
         n_err++; $display("FAIL ill_clear: got seen=%b pc=%h want 0 0", illegal_seen, illegal_pc);
      end
      illegal_clear = 0; in_valid = 1; pc_in = 32'h20C;
      tick();
      illegal_clear = 1; pc_in = 32'h210;
      tick();
      n_checks++;
      if ({illegal_seen, illegal_pc} !== {1'b1, 32'h210}) begin
         n_err++; $display("FAIL ill_clear_and_set: got seen=%b pc=%h want 1 210", illegal_seen, illegal_pc);
      end
      illegal_clear = 0; in_valid = 0;
   endtask

   task automatic test_flush();
      in_valid = 1; instruction = enc_r(0, 2, 1, 0, 4); pc_in = 32'h300;
      tick();
      flush = 1; instruction = 32'h0000_007F; pc_in = 32'h304;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      tick();
      n_checks++;
      if ({out_valid, illegal_seen, illegal_pc} !== {1'b0, 1'b1, 32'h210}) begin
         n_err++; $display("FAIL flush_drop: got v=%b seen=%b pc=%h want 0 1 210", out_valid, illegal_seen, illegal_pc);
      end
      flush = 0; in_valid = 0;
   endtask

   task automatic test_bypass();
      logic [31:0] exp;
`ifdef DECODE_WB_BYPASS_EN
      exp = 32'h1234;
`else
      exp = 32'h1111;
`endif
      wb_en = 1; wb_id = 7; wb_data = 32'h1111;
      tick();
      wb_data = 32'h1234; in_valid = 1; instruction = enc_r(0, 0, 7, 0, 1); pc_in = 32'h400;
      tick();
      n_checks++;
      if (out_read_data1 !== exp) begin n_err++; $display("FAIL wb_same_cycle: got %h want %h", out_read_data1, exp); end
      wb_en = 0; pc_in = 32'h404;
      tick();
      n_checks++;
      if (out_read_data1 !== 32'h1234) begin n_err++; $display("FAIL wb_after: got %h want 1234", out_read_data1); end
      wb_en = 1; wb_id = 0; wb_data = 32'hDEAD; instruction = enc_r(0, 0, 0, 0, 1); pc_in = 32'h408;
      tick();
      wb_en = 0; pc_in = 32'h40C;
      tick();
      n_checks++;
      if (out_read_data1 !== 32'h0) begin n_err++; $display("FAIL x0_write: got %h want 0", out_read_data1); end
      in_valid = 0;
   endtask

   task automatic test_random();
      logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      for (int c = 0; c < 800; c++) begin
         instruction = $urandom();
         if ($urandom_range(3) != 0) instruction[6:0] = ops[$urandom_range(8)];
         pc_in      = $urandom();
         in_valid   = ($urandom_range(9) < 7);
         out_ready  = ($urandom_range(9) < 7);
         flush      = ($urandom_range(19) == 0);
         ex_is_load = ($urandom_range(4) == 0);
         ex_rd_id   = ($urandom_range(1) == 0) ? instruction[19:15] : 5'($urandom_range(31));
         wb_en      = $urandom_range(1);
         wb_id      = ($urandom_range(1) == 0) ? instruction[24:20] : 5'($urandom_range(31));
         wb_data    = $urandom();
         illegal_clear = ($urandom_range(19) == 0);
         #1;
         n_checks++;
         if (in_ready !== ref_ready()) begin
            n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, ref_ready());
         end
         tick();
         n_checks++;
         if ({out_valid, illegal_seen, illegal_pc} !== {m_valid, m_seen, m_ipc}) begin
            n_err++; $display("FAIL rnd_state[%0d]: got v=%b seen=%b ipc=%h want %b %b %h",
                              c, out_valid, illegal_seen, illegal_pc, m_valid, m_seen, m_ipc);
         end
         if (m_valid) begin
            n_checks++;
            if ({out_rd_id, out_rs1_id, out_rs2_id, out_read_data1, out_read_data2, out_imm, out_pc, out_illegal,
                 out_control.reg_write, out_control.mem_read, out_control.mem_write, out_control.branch, out_control.jump}
                !== {m_rd, m_rs1, m_rs2, m_d1, m_d2, m_imm, m_pc, m_ill, m_ctl}) begin
               n_err++;
               $display("FAIL rnd_fields[%0d]: got rd=%0d rs=%0d,%0d d=%h,%h imm=%h pc=%h ill=%b want rd=%0d rs=%0d,%0d d=%h,%h imm=%h pc=%h ill=%b ctl=%b",
                        c, out_rd_id, out_rs1_id, out_rs2_id, out_read_data1, out_read_data2, out_imm, out_pc,
                        out_illegal, m_rd, m_rs1, m_rs2, m_d1, m_d2, m_imm, m_pc, m_ill, m_ctl);
            end
         end
      end
      set_idle();
      tick();
   endtask

   task automatic test_async_reset();
      in_valid = 1; instruction = 32'h0000_007F; pc_in = 32'h500;
      tick();
      in_valid = 0;
      #2;
      reset = 1;
      #1;
      model_reset();
      n_checks++;
      if ({out_valid, illegal_seen, illegal_pc, in_ready} !== '0) begin
         n_err++; $display("FAIL async_reset: got v=%b seen=%b ipc=%h rdy=%b want all 0",
                           out_valid, illegal_seen, illegal_pc, in_ready);
      end
      @(negedge clk);
      reset = 0;
      @(posedge clk); #1;
      in_valid = 1; instruction = enc_r(0, 7, 5, 0, 1); pc_in = 32'h600;
      tick();
      n_checks++;
      if ({out_valid, out_read_data1, out_read_data2} !== {1'b1, 64'h0}) begin
         n_err++; $display("FAIL rf_reset: got v=%b d1=%h d2=%h want 1 0 0", out_valid, out_read_data1, out_read_data2);
      end
      in_valid = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_stall();
      test_illegal();
      test_flush();
      test_bypass();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
